// File: rtl/pmod_pwm_pkg.sv
// Shared constants for the PMOD PWM driver and the board top levels that consume PWM_OUT.
package pmod_pwm_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int CHAN_W       = 5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  // PWM_OUT bit index for each PMOD signal pin (pins 5/6/11/12 are power)
  localparam int PIN_A1 = 0,  PIN_A2 = 1,  PIN_A3 = 2,  PIN_A4 = 3;
  localparam int PIN_A7 = 4,  PIN_A8 = 5,  PIN_A9 = 6,  PIN_A10 = 7;
  localparam int PIN_B1 = 8,  PIN_B2 = 9,  PIN_B3 = 10, PIN_B4 = 11;
  localparam int PIN_B7 = 12, PIN_B8 = 13, PIN_B9 = 14, PIN_B10 = 15;
  localparam int PIN_C1 = 16, PIN_C2 = 17, PIN_C3 = 18, PIN_C4 = 19;
  localparam int PIN_C7 = 20, PIN_C8 = 21, PIN_C9 = 22, PIN_C10 = 23;
  localparam int PIN_D1 = 24, PIN_D2 = 25, PIN_D3 = 26, PIN_D4 = 27;
  localparam int PIN_D7 = 28, PIN_D8 = 29, PIN_D9 = 30, PIN_D10 = 31;

endpackage

// File: rtl/pmod_pwm_driver_timebase.sv
// PWM timebase: prescaler feeding a free-running period counter; flags tick and period wrap.
module pwm_timebase
  import pmod_pwm_pkg::*;
#(
  parameter int PRESCALE = 188,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                wrap
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    wrap  = tick && (cnt_q == '1);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign pwm_cnt = cnt_q;

endmodule

// File: rtl/pmod_pwm_driver.sv
// 32-channel PWM driver: shadow/active duty banks swapped only on a period wrap.
//  state      | meaning
//  ST_IDLE    | no commit outstanding, writes accepted
//  ST_PENDING | commit requested, waiting for next wrap to copy shadow -> active
module pmod_pwm_driver
  import pmod_pwm_pkg::*;
#(
  parameter int CHANNELS = 32,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = 188
) (
  input  logic                CLK_48,
  input  logic                RST,
  input  logic                WR_VALID,
  output logic                WR_READY,
  input  logic [CHAN_W-1:0]   WR_CHAN,
  input  logic [PWM_BITS-1:0] WR_DUTY,
  input  logic                COMMIT,
  output logic                BUSY,
  output logic                FRAME_STROBE,
  output logic [CHANNELS-1:0] PWM_OUT
);

  commit_state_e       state_q, state_d;
  logic                rst_d_q;
  logic                strobe_q;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] shadow_q [CHANNELS];
  logic [PWM_BITS-1:0] shadow_d [CHANNELS];
  logic [PWM_BITS-1:0] active_q [CHANNELS];
  logic [PWM_BITS-1:0] active_d [CHANNELS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                wrap;
  logic                wr_fire;
  logic                swap;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk     (CLK_48),
    .rst     (RST),
    .pwm_cnt (pwm_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  assign BUSY         = (state_q == ST_PENDING);
  assign WR_READY     = ~BUSY & ~rst_d_q & ~RST;
  assign wr_fire      = WR_VALID & WR_READY;
  assign FRAME_STROBE = strobe_q;
  assign PWM_OUT      = pwm_q;

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // a commit landing on a wrap cycle waits for the following wrap
        if (COMMIT) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (wrap) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    // out-of-range channels complete the handshake but match no entry
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_fire && (WR_CHAN == CHAN_W'(i))) shadow_d[i] = WR_DUTY;
    end
    if (swap) active_d = shadow_q;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (active_q[i] == '1) || (pwm_cnt < active_q[i]);
    end
  end

  always_ff @(posedge CLK_48) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      rst_d_q  <= 1'b1;
      strobe_q <= 1'b0;
      pwm_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rst_d_q  <= 1'b0;
      strobe_q <= wrap;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_pmod_pwm_driver.sv
// Self-checking bench for pmod_pwm_driver (PRESCALE=2, PWM_BITS=8 -> 512-cycle period).
module tb_pmod_pwm_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_chan = '0;
  logic [7:0]  wr_duty = '0;
  logic        commit = 1'b0;
  logic        wr_ready, busy, strobe;
  logic [31:0] pwm;

  // narrow instance so an out-of-range channel index is representable on the 5-bit port
  logic        s_wr_valid = 1'b0;
  logic [4:0]  s_wr_chan = '0;
  logic [7:0]  s_wr_duty = '0;
  logic        s_commit = 1'b0;
  logic        s_wr_ready, s_busy, s_strobe;
  logic [7:0]  s_pwm;

  pmod_pwm_driver #(.CHANNELS(32), .PWM_BITS(8), .PRESCALE(2)) u_dut (
    .CLK_48(clk), .RST(rst), .WR_VALID(wr_valid), .WR_READY(wr_ready),
    .WR_CHAN(wr_chan), .WR_DUTY(wr_duty), .COMMIT(commit), .BUSY(busy),
    .FRAME_STROBE(strobe), .PWM_OUT(pwm)
  );

  pmod_pwm_driver #(.CHANNELS(8), .PWM_BITS(8), .PRESCALE(2)) u_dut_small (
    .CLK_48(clk), .RST(rst), .WR_VALID(s_wr_valid), .WR_READY(s_wr_ready),
    .WR_CHAN(s_wr_chan), .WR_DUTY(s_wr_duty), .COMMIT(s_commit), .BUSY(s_busy),
    .FRAME_STROBE(s_strobe), .PWM_OUT(s_pwm)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [4:0] chan;
    logic [7:0] duty;
    int         exp_hi;
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;
  int   hi[32];
  int   hs[8];
  int   nstb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write(input logic [4:0] ch, input logic [7:0] d);
    check("wr_ready_at_write", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1; wr_chan = ch; wr_duty = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic s_write(input logic [4:0] ch, input logic [7:0] d);
    check("s_wr_ready_at_write", {31'd0, s_wr_ready}, 1);
    s_wr_valid = 1'b1; s_wr_chan = ch; s_wr_duty = d;
    @(negedge clk);
    s_wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_strobe(output int steps);
    steps = 0;
    while (strobe !== 1'b1 && steps < 1200) begin
      @(negedge clk);
      steps++;
    end
    if (strobe !== 1'b1) check("strobe_timeout", {31'd0, strobe}, 1);
  endtask

  // call on a strobe cycle; samples one full period and ends on the next strobe cycle
  task automatic measure();
    for (int i = 0; i < 32; i++) hi[i] = 0;
    for (int i = 0; i < 8; i++) hs[i] = 0;
    nstb = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      for (int i = 0; i < 32; i++) hi[i] += int'(pwm[i]);
      for (int i = 0; i < 8; i++) hs[i] += int'(s_pwm[i]);
      nstb += int'(strobe);
    end
    check("strobe_pulses_per_period", nstb, 1);
    check("strobe_at_period_end", {31'd0, strobe}, 1);
  endtask

  initial begin
    int steps;
    int falls;
    int total;
    logic prev;

    vecs[0] = '{chan: 5'd0,  duty: 8'd64,  exp_hi: 128};
    vecs[1] = '{chan: 5'd31, duty: 8'd255, exp_hi: 512};
    vecs[2] = '{chan: 5'd5,  duty: 8'd0,   exp_hi: 0};
    vecs[3] = '{chan: 5'd3,  duty: 8'd10,  exp_hi: 20};
    vecs[4] = '{chan: 5'd7,  duty: 8'd1,   exp_hi: 2};
    vecs[5] = '{chan: 5'd12, duty: 8'd254, exp_hi: 508};
    vecs[6] = '{chan: 5'd20, duty: 8'd128, exp_hi: 256};

    // power-on reset
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, wr_ready}, 0);
    check("rst_strobe", {31'd0, strobe}, 0);
    rst = 1'b0;
    check("ready_release_cycle", {31'd0, wr_ready}, 0);
    @(negedge clk);
    check("ready_after_release", {31'd0, wr_ready}, 1);
    wait_strobe(steps);
    check("first_wrap_latency", steps, 511);

    // table of duties, single commit
    for (int v = 0; v < 7; v++) write(vecs[v].chan, vecs[v].duty);
    pulse_commit();
    check("busy_after_commit", {31'd0, busy}, 1);
    check("ready_while_busy", {31'd0, wr_ready}, 0);
    wait_strobe(steps);
    check("busy_cleared_at_swap", {31'd0, busy}, 0);
    measure();
    for (int v = 0; v < 7; v++) check($sformatf("duty_ch%0d", vecs[v].chan), hi[vecs[v].chan], vecs[v].exp_hi);
    check("duty_ch1_unwritten", hi[1], 0);

    // commit on the wrap cycle defers the swap one period
    write(5'd0, 8'd32);
    repeat (510) @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("strobe_on_commit_wrap", {31'd0, strobe}, 1);
    check("busy_after_wrap_commit", {31'd0, busy}, 1);
    measure();
    check("ch0_not_swapped_yet", hi[0], 128);
    check("busy_cleared_next_wrap", {31'd0, busy}, 0);
    measure();
    check("ch0_swapped_next_wrap", hi[0], 64);

    // out-of-range channel on the 8-channel instance: accepted, dropped, no aliasing
    s_write(5'd4, 8'd255);
    s_write(5'd12, 8'd200);
    s_commit = 1'b1;
    @(negedge clk);
    s_commit = 1'b0;
    check("s_busy_after_commit", {31'd0, s_busy}, 1);
    wait_strobe(steps);
    check("s_busy_cleared", {31'd0, s_busy}, 0);
    measure();
    check("s_ch4_full", hs[4], 512);
    total = 0;
    for (int i = 0; i < 8; i++) if (i != 4) total += hs[i];
    check("s_other_channels_low", total, 0);
    check("big_ch0_unchanged", hi[0], 64);
    check("big_ch31_unchanged", hi[31], 512);

    // shadow write without commit stays invisible; second commit while busy ignored
    write(5'd3, 8'd128);
    wait_strobe(steps);
    for (int p = 0; p < 3; p++) begin
      measure();
      check($sformatf("ch3_uncommitted_p%0d", p), hi[3], 20);
    end
    pulse_commit();
    check("busy_first_commit", {31'd0, busy}, 1);
    pulse_commit();
    check("busy_second_commit", {31'd0, busy}, 1);
    falls = 0;
    prev  = busy;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (prev && !busy) falls++;
      prev = busy;
    end
    check("busy_fall_count", falls, 1);
    check("busy_idle_after", {31'd0, busy}, 0);
    wait_strobe(steps);
    measure();
    check("ch3_committed", hi[3], 256);

    // write and commit in the same cycle
    check("ready_write_commit", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1; wr_chan = 5'd7; wr_duty = 8'd200; commit = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; commit = 1'b0;
    check("busy_write_commit", {31'd0, busy}, 1);
    wait_strobe(steps);
    measure();
    check("ch7_same_cycle", hi[7], 400);
    check("ch3_retained", hi[3], 256);

    // reset mid-period with a commit pending
    write(5'd2, 8'd50);
    pulse_commit();
    check("busy_before_reset", {31'd0, busy}, 1);
    repeat (100) @(negedge clk);
    check("ch31_high_before_reset", {31'd0, pwm[31]}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", pwm, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ready", {31'd0, wr_ready}, 0);
    check("midrst_strobe", {31'd0, strobe}, 0);
    repeat (3) @(negedge clk);
    check("midrst_ready_held", {31'd0, wr_ready}, 0);
    rst = 1'b0;
    check("midrst_ready_release_cycle", {31'd0, wr_ready}, 0);
    @(negedge clk);
    check("midrst_ready_after", {31'd0, wr_ready}, 1);
    wait_strobe(steps);
    check("midrst_wrap_latency", steps, 511);
    measure();
    total = 0;
    for (int i = 0; i < 32; i++) total += hi[i];
    check("midrst_banks_cleared", total, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
